div_unit: RTL and testbench
===========================

# div_unit

Iterative RV32M divide/remainder unit. It sits directly downstream of the register file and takes the two read ports (rdata1/rdata2) as dividend and divisor. It stalls the single-cycle core while it iterates, then presents a 32-bit result for write-back to the register file in exactly one cycle. Latency is fixed: one quotient bit per cycle, using restoring division on magnitudes.

## Interface
- XLEN, 32, operand/result width; iteration count equals XLEN.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- start_i  in  1  valid divide instruction in decode; sampled only in IDLE.
- op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start_i.
- rs1_data_i  in  XLEN  dividend (register file rdata1).
- rs2_data_i  in  XLEN  divisor (register file rdata2).
- stall_o  out  1  combinational; freeze PC and suppress write-back.
- valid_o  out  1  registered; result_o is valid for write-back this cycle.
- result_o  out  XLEN  registered quotient or remainder per latched op.

## Operation
- States: IDLE, CALC, DONE. A counter of $clog2(XLEN)+1 bits counts iterations.
- IDLE, start_i=1:
  - Latch op, both operand signs, |dividend| and |divisor| (signed ops only; unsigned ops take raw values), and the divisor-zero flag.
  - Clear the remainder accumulator; counter = XLEN.
  - Go to CALC, or to DONE via the fast path (see Configuration).
- CALC, each cycle:
  - Shift {rem, quo} left 1 and trial-subtract the divisor.
  - If no borrow, keep the difference and set quo[0]=1.
  - Decrement counter; on the 1→0 transition go to DONE and register result_o.
- DONE: valid_o=1 for one cycle, then unconditionally go to IDLE. start_i is ignored in DONE and CALC.
- Sign fix for DIV/REM:
  - Quotient is negated iff the operand signs differ and divisor≠0.
  - Remainder takes the sign of the dividend.
- Divide by zero: quotient = all ones (0xFFFFFFFF), remainder = dividend, for both signed and unsigned ops.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- stall_o = (IDLE & start_i) | CALC. It is low in DONE so the core commits that cycle.
- Reset values: state IDLE, counter 0, result_o 0, valid_o 0, stall_o 0 (given start_i low).
- Reset mid-operation aborts with no valid_o pulse; the next cycle is IDLE.

## Timing
- Edge E0 samples start_i in IDLE.
- Normal path:
  - CALC occupies edges E1..EXLEN.
  - DONE and valid_o fall in the cycle after EXLEN.
  - stall_o is high from the start_i cycle through the last CALC cycle: XLEN+1 cycles.
- Fast path: DONE and valid_o fall in the cycle after E0; stall_o is high for 1 cycle.
- Operands need only be stable in the start_i cycle. rs1/rs2 may change afterwards.
- valid_o never asserts on two consecutive cycles.
- A start_i held high through DONE does not restart the unit. The core is responsible for issuing the next instruction.

## Configuration
- DIV_FAST_PATH_EN defined:
  - Divide-by-zero and signed overflow go IDLE→DONE directly with the mandated results.
  - Same fast path when the unsigned magnitudes satisfy dividend < divisor: quotient 0, remainder = dividend.
- DIV_FAST_PATH_EN undefined:
  - Every operation runs the full XLEN CALC cycles.
  - Results are bit-identical to the defined case; only latency differs.

## Test plan
- Reset: rst_ni=0 for 2 cycles during CALC of 100/7 → valid_o=0, result_o=0, stall_o=0. A new DIVU 100/7 then returns 14 after XLEN+1 stall cycles.
- DIVU 0xFFFFFFFF/3 → 0x55555555; REMU 100/7 → 2. valid_o pulses once, XLEN+1 cycles after start.
- Signed: DIV -7/2 → 0xFFFFFFFD (-3); REM -7/2 → 0xFFFFFFFF (-1); DIV 7/-2 → -3; REM 7/-2 → 1.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x1234. Latency is 1 cycle with DIV_FAST_PATH_EN, XLEN+1 without.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- Back-to-back: start_i held high and op/operands changed mid-CALC → first result unaffected. The second op starts only from IDLE, and valid_o is never high two cycles in a row.

Source files
------------

// File: rtl/div_if.sv
// Handshake/bus bundle between decode/register file and the iterative divider.
// The core drives the master side; div_unit is the slave.
interface div_if #(
   parameter int XLEN = 32
);
   logic            start_i;
   logic [1:0]      op_i;
   logic [XLEN-1:0] rs1_data_i;
   logic [XLEN-1:0] rs2_data_i;
   logic            stall_o;
   logic            valid_o;
   logic [XLEN-1:0] result_o;

   modport slave (
      input  start_i, op_i, rs1_data_i, rs2_data_i,
      output stall_o, valid_o, result_o
   );

   modport master (
      output start_i, op_i, rs1_data_i, rs2_data_i,
      input  stall_o, valid_o, result_o
   );
endinterface

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU: restoring division on magnitudes, one quotient bit per cycle.
// Optional DIV_FAST_PATH_EN: div-by-zero, signed overflow and |dividend|<|divisor| finish in one cycle.
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic clk_i,
   input  logic rst_ni,
   div_if.slave io
);

   localparam int CW = $clog2(XLEN) + 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic            rem_op_q, s1_q, s2_q, dz_q;
   logic [XLEN-1:0] acc_q, quo_q, dvs_q;
   logic [XLEN-1:0] result_q, result_d;
   logic            valid_q;

   // operand decode in the start_i cycle
   logic            is_signed, in_s1, in_s2, in_dz;
   logic [XLEN-1:0] mag1, mag2;
   logic            fast;
   logic [XLEN-1:0] fast_res;

   assign is_signed = ~io.op_i[0];
   assign in_s1     = is_signed & io.rs1_data_i[XLEN-1];
   assign in_s2     = is_signed & io.rs2_data_i[XLEN-1];
   assign mag1      = in_s1 ? -io.rs1_data_i : io.rs1_data_i;
   assign mag2      = in_s2 ? -io.rs2_data_i : io.rs2_data_i;
   assign in_dz     = (io.rs2_data_i == '0);

`ifdef DIV_FAST_PATH_EN
   logic in_ovf;
   assign in_ovf = is_signed & (io.rs1_data_i == {1'b1, {(XLEN-1){1'b0}}})
                             & (io.rs2_data_i == '1);

   always_comb begin
      fast     = 1'b0;
      fast_res = '0;
      if (in_dz) begin
         fast     = 1'b1;
         fast_res = io.op_i[1] ? io.rs1_data_i : '1;
      end else if (in_ovf) begin
         fast     = 1'b1;
         fast_res = io.op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end else if (mag1 < mag2) begin
         fast     = 1'b1;
         fast_res = io.op_i[1] ? io.rs1_data_i : '0;
      end
   end
`else
   assign fast     = 1'b0;
   assign fast_res = '0;
`endif

   // one restoring step; the shifted remainder needs XLEN+1 bits before the trial subtract
   logic [XLEN:0]   acc_sh;
   logic [XLEN-1:0] diff, acc_nx, quo_nx, quo_fix, acc_fix, calc_res;
   logic            no_borrow;

   always_comb begin
      acc_sh    = {acc_q, quo_q[XLEN-1]};
      no_borrow = (acc_sh >= {1'b0, dvs_q});
      diff      = acc_sh[XLEN-1:0] - dvs_q;
      acc_nx    = no_borrow ? diff : acc_sh[XLEN-1:0];
      quo_nx    = {quo_q[XLEN-2:0], no_borrow};
      quo_fix   = ((s1_q ^ s2_q) & ~dz_q) ? -quo_nx : quo_nx;
      acc_fix   = s1_q ? -acc_nx : acc_nx;
      calc_res  = rem_op_q ? acc_fix : quo_fix;
   end

   assign result_d = (state_q == IDLE) ? fast_res : calc_res;

   // FSM: state register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (io.start_i) state_d = fast ? DONE : CALC;
         CALC:    if (cnt_q == CW'(1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      io.stall_o = ((state_q == IDLE) & io.start_i) | (state_q == CALC);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         rem_op_q <= 1'b0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         dz_q     <= 1'b0;
         acc_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (io.start_i) begin
               rem_op_q <= io.op_i[1];
               s1_q     <= in_s1;
               s2_q     <= in_s2;
               dz_q     <= in_dz;
               acc_q    <= '0;
               quo_q    <= mag1;
               dvs_q    <= mag2;
               cnt_q    <= CW'(XLEN);
            end
            CALC: begin
               acc_q <= acc_nx;
               quo_q <= quo_nx;
               cnt_q <= cnt_q - CW'(1);
            end
            default: ;
         endcase
         valid_q <= (state_d == DONE);
         if (state_d == DONE) result_q <= result_d;
      end
   end

   assign io.valid_o  = valid_q;
   assign io.result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: reference results from SV arithmetic, latency/stall counts per op.
module tb_div_unit;
   localparam int XLEN     = 32;
   localparam int NORM_LAT = XLEN + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   div_if #(.XLEN(XLEN)) bus ();
   div_unit #(.XLEN(XLEN)) dut (.clk_i(clk), .rst_ni(rst_n), .io(bus));

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic        prev_valid = 1'b0;

   always @(negedge clk) begin
      if (bus.valid_o === 1'b1) begin
         checks++;
         if (prev_valid) begin
            errors++;
            $display("FAIL valid_twice: valid_o high two cycles in a row at %0t", $time);
         end
      end
      prev_valid = (bus.valid_o === 1'b1);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
      case (op)
         2'b00:   return sa / sb;
         2'b01:   return a / b;
         2'b10:   return sa % sb;
         default: return a % b;
      endcase
   endfunction

   function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FAST_PATH_EN
      logic        sg;
      logic [31:0] ma, mb;
      sg = ~op[0];
      ma = (sg && a[31]) ? -a : a;
      mb = (sg && b[31]) ? -b : b;
      if (b == 32'd0 || (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || ma < mb) return 1;
`endif
      return NORM_LAT;
   endfunction

   // Waits for valid_o; counts cycles after the start cycle and stall cycles seen on the way.
   task automatic wait_valid(input logic hold, input logic chg, input logic [1:0] nop,
                             input logic [31:0] na, input logic [31:0] nb,
                             output int cyc, output int stalls, output logic got);
      cyc = 0; stalls = 0; got = 1'b0;
      while (!got && cyc < 200) begin
         #1;
         if (bus.stall_o === 1'b1) stalls++;
         if (bus.valid_o === 1'b1) got = 1'b1;
         else begin
            @(negedge clk);
            cyc++;
            if (!hold) bus.start_i = 1'b0;
            if (chg && cyc == 5) begin
               bus.op_i = nop; bus.rs1_data_i = na; bus.rs2_data_i = nb;
            end
         end
      end
   endtask

   task automatic check_done(input string name, input logic got, input int cyc, input int stalls, input int el);
      logic [31:0] exp;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s_timeout: valid_o never seen, required within %0d cycles", name, el);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         return;
      end
      exp = exp_q.pop_front();
      checks++;
      if (bus.result_o !== exp) begin
         errors++;
         $display("FAIL %s_result: got %08h expected %08h", name, bus.result_o, exp);
      end
      checks++;
      if (cyc !== el) begin
         errors++;
         $display("FAIL %s_latency: got %0d expected %0d", name, cyc, el);
      end
      checks++;
      if (stalls !== el) begin
         errors++;
         $display("FAIL %s_stall_cycles: got %0d expected %0d", name, stalls, el);
      end
   endtask

   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int cyc, stalls, el;
      logic got;
      @(negedge clk);
      bus.op_i = op; bus.rs1_data_i = a; bus.rs2_data_i = b; bus.start_i = 1'b1;
      exp_q.push_back(ref_res(op, a, b));
      el = exp_lat(op, a, b);
      wait_valid(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, cyc, stalls, got);
      bus.start_i = 1'b0;
      check_done(name, got, cyc, stalls, el);
   endtask

   task automatic test_reset();
      int seen;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (bus.valid_o !== 1'b0 || bus.result_o !== 32'd0 || bus.stall_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: valid=%b result=%08h stall=%b expected 0/0/0", bus.valid_o, bus.result_o, bus.stall_o);
      end
      rst_n = 1'b1;
      // start DIVU 100/7 and abort it mid-CALC
      @(negedge clk);
      bus.op_i = 2'b01; bus.rs1_data_i = 32'd100; bus.rs2_data_i = 32'd7; bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (bus.valid_o !== 1'b0 || bus.result_o !== 32'd0 || bus.stall_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_midop: valid=%b result=%08h stall=%b expected 0/0/0", bus.valid_o, bus.result_o, bus.stall_o);
      end
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.valid_o === 1'b1 || bus.stall_o === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL reset_abort: %0d cycles of valid/stall after abort, expected 0", seen);
      end
      run_op("reset_divu_100_7", 2'b01, 32'd100, 32'd7);
   endtask

   task automatic test_unsigned();
      run_op("divu_ffffffff_3", 2'b01, 32'hFFFF_FFFF, 32'd3);
      run_op("remu_100_7",      2'b10 | 2'b01, 32'd100, 32'd7);
      for (int i = 0; i < 4; i++)
         run_op("rand_op", 2'($urandom), $urandom, $urandom >> $urandom_range(0, 31));
   endtask

   task automatic test_signed();
      run_op("div_m7_2", 2'b00, -32'sd7, 32'd2);
      run_op("rem_m7_2", 2'b10, -32'sd7, 32'd2);
      run_op("div_7_m2", 2'b00, 32'd7, -32'sd2);
      run_op("rem_7_m2", 2'b10, 32'd7, -32'sd2);
   endtask

   task automatic test_div_zero();
      run_op("div_5_0",      2'b00, 32'd5, 32'd0);
      run_op("remu_1234_0",  2'b11, 32'h1234, 32'd0);
      run_op("rem_m5_0",     2'b10, -32'sd5, 32'd0);
      run_op("divu_0_0",     2'b01, 32'd0, 32'd0);
   endtask

   task automatic test_overflow();
      run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
   endtask

   task automatic test_small();
      run_op("divu_3_10", 2'b01, 32'd3, 32'd10);
      run_op("rem_m3_10", 2'b10, -32'sd3, 32'd10);
      run_op("div_10_10", 2'b00, 32'd10, 32'd10);
   endtask

   task automatic test_back_to_back();
      int cyc, stalls;
      logic got;
      @(negedge clk);
      bus.op_i = 2'b01; bus.rs1_data_i = 32'd1000; bus.rs2_data_i = 32'd10; bus.start_i = 1'b1;
      exp_q.push_back(ref_res(2'b01, 32'd1000, 32'd10));
      // operands switch to the second op mid-CALC while start_i stays high
      wait_valid(1'b1, 1'b1, 2'b00, -32'sd50, 32'd7, cyc, stalls, got);
      check_done("b2b_first", got, cyc, stalls, NORM_LAT);
      @(negedge clk);
      exp_q.push_back(ref_res(2'b00, -32'sd50, 32'd7));
      wait_valid(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, cyc, stalls, got);
      bus.start_i = 1'b0;
      check_done("b2b_second", got, cyc, stalls, exp_lat(2'b00, -32'sd50, 32'd7));
      repeat (3) @(negedge clk);
   endtask

   initial begin
      bus.start_i = 1'b0; bus.op_i = 2'b00; bus.rs1_data_i = '0; bus.rs2_data_i = '0;
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_overflow();
      test_small();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
